// File: rtl/alu.sv
// Registered ALU: AND/OR/ADD/SUB/SLT with Overflow/CarryOut/Zero flags, one-cycle latency.
// Define ALU_EXT_OPS_EN to add XOR (100), NOR (101) and SLTU (011).
module alu #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       ALUop,
  output logic             Overflow,
  output logic             CarryOut,
  output logic             Zero,
  output logic [WIDTH-1:0] Result
);

  localparam logic [2:0] OpAnd  = 3'b000;
  localparam logic [2:0] OpOr   = 3'b001;
  localparam logic [2:0] OpAdd  = 3'b010;
  localparam logic [2:0] OpSub  = 3'b110;
  localparam logic [2:0] OpSlt  = 3'b111;
`ifdef ALU_EXT_OPS_EN
  localparam logic [2:0] OpSltu = 3'b011;
  localparam logic [2:0] OpXor  = 3'b100;
  localparam logic [2:0] OpNor  = 3'b101;
`endif

  logic             sub;
  logic [WIDTH-1:0] b_x;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] diff;
  logic             carry;
  logic             ovf;
  logic             lt;
`ifdef ALU_EXT_OPS_EN
  logic             ltu;
`endif

  logic [WIDTH-1:0] result_d;
  logic             overflow_d;
  logic             carry_d;

  // One shared adder; subtraction is A + ~B + 1.
  always_comb begin
`ifdef ALU_EXT_OPS_EN
    sub = (ALUop == OpSub) || (ALUop == OpSlt) || (ALUop == OpSltu);
`else
    sub = (ALUop == OpSub) || (ALUop == OpSlt);
`endif
    b_x   = sub ? ~B : B;
    sum   = {1'b0, A} + {1'b0, b_x} + {{WIDTH{1'b0}}, sub};
    diff  = sum[WIDTH-1:0];
    carry = sum[WIDTH];
    ovf   = (A[WIDTH-1] == b_x[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
    // Sign of the difference corrected by overflow gives the true signed compare.
    lt    = diff[WIDTH-1] ^ ovf;
`ifdef ALU_EXT_OPS_EN
    ltu   = ~carry;
`endif
  end

  always_comb begin
    result_d   = '0;
    overflow_d = 1'b0;
    carry_d    = 1'b0;
    case (ALUop)
      OpAnd: result_d = A & B;
      OpOr:  result_d = A | B;
      OpAdd: begin
        result_d   = diff;
        overflow_d = ovf;
        carry_d    = carry;
      end
      OpSub: begin
        result_d   = diff;
        overflow_d = ovf;
        carry_d    = ~carry;
      end
      OpSlt: result_d = {{(WIDTH-1){1'b0}}, lt};
`ifdef ALU_EXT_OPS_EN
      OpSltu: result_d = {{(WIDTH-1){1'b0}}, ltu};
      OpXor:  result_d = A ^ B;
      OpNor:  result_d = ~(A | B);
`endif
      default: result_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      Result   <= '0;
      Overflow <= 1'b0;
      CarryOut <= 1'b0;
      Zero     <= 1'b1;
    end else begin
      Result   <= result_d;
      Overflow <= overflow_d;
      CarryOut <= carry_d;
      Zero     <= (result_d == '0);
    end
  end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed corner cases plus randomised back-to-back ops
// against a behavioural model, with expected results queued in a scoreboard.
module tb_alu;

  logic        clk;
  logic        resetn;
  logic [31:0] A;
  logic [31:0] B;
  logic [2:0]  ALUop;
  logic        Overflow;
  logic        CarryOut;
  logic        Zero;
  logic [31:0] Result;

  typedef struct packed {
    logic [31:0] r;
    logic        o;
    logic        c;
    logic        z;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  alu #(.WIDTH(32)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .A        (A),
    .B        (B),
    .ALUop    (ALUop),
    .Overflow (Overflow),
    .CarryOut (CarryOut),
    .Zero     (Zero),
    .Result   (Result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [32:0] s;
    logic        lt;
    e  = '0;
    s  = '0;
    lt = ($signed(a) < $signed(b));
    case (op)
      3'b000: e.r = a & b;
      3'b001: e.r = a | b;
      3'b010: begin
        s   = {1'b0, a} + {1'b0, b};
        e.r = s[31:0];
        e.c = s[32];
        e.o = (a[31] == b[31]) && (e.r[31] != a[31]);
      end
      3'b110: begin
        e.r = a - b;
        e.c = (a < b);
        e.o = (a[31] != b[31]) && (e.r[31] != a[31]);
      end
      3'b111: e.r = {31'b0, lt};
`ifdef ALU_EXT_OPS_EN
      3'b011: e.r = {31'b0, (a < b)};
      3'b100: e.r = a ^ b;
      3'b101: e.r = ~(a | b);
`endif
      default: e.r = '0;
    endcase
    e.z = (e.r == 32'd0);
    return e;
  endfunction

  // Drive one operation, queue its expectation, and advance past the sampling edge.
  task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    ALUop = op;
    A     = a;
    B     = b;
    if (!resetn) e = '{r: 32'd0, o: 1'b0, c: 1'b0, z: 1'b1};
    else         e = model(op, a, b);
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e, got;
    resetn = 1'b0;
    drive(3'b010, 32'd5, 32'd3);
    got = {Result, Overflow, CarryOut, Zero};
    e   = sb.pop_front();
    checks++;
    if (got !== e || e.z !== 1'b1) begin
      errors++;
      $display("FAIL reset: got %h, required %h", got, e);
    end
    resetn = 1'b1;
    drive(3'b010, 32'd5, 32'd3);
    got = {Result, Overflow, CarryOut, Zero};
    e   = sb.pop_front();
    checks++;
    if (got !== e || Result !== 32'd8) begin
      errors++;
      $display("FAIL reset_release: got %h, required %h", got, e);
    end
  endtask

  task automatic run_table(input string name, input logic [2:0] ops[],
                           input logic [31:0] as[], input logic [31:0] bs[]);
    exp_t e, got;
    for (int i = 0; i < ops.size(); i++) begin
      drive(ops[i], as[i], bs[i]);
      got = {Result, Overflow, CarryOut, Zero};
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL %s[%0d]: scoreboard empty", name, i);
      end else begin
        e = sb.pop_front();
        checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL %s[%0d] op=%b a=%h b=%h: got r=%h o=%b c=%b z=%b, required r=%h o=%b c=%b z=%b",
                   name, i, ops[i], as[i], bs[i], Result, Overflow, CarryOut, Zero,
                   e.r, e.o, e.c, e.z);
        end
      end
    end
  endtask

  task automatic test_logic();
    logic [2:0]  ops[] = '{3'b000, 3'b000, 3'b001};
    logic [31:0] as[]  = '{32'hFFFFFFFF, 32'h11110001, 32'h11110001};
    logic [31:0] bs[]  = '{32'hFFFFFFFF, 32'h00000001, 32'h00000001};
    run_table("logic", ops, as, bs);
  endtask

  task automatic test_add();
    logic [2:0]  ops[] = '{3'b010, 3'b010, 3'b010};
    logic [31:0] as[]  = '{32'h7FFFFFFF, 32'h80000001, 32'h0};
    logic [31:0] bs[]  = '{32'h00000001, 32'hFFFFFFF2, 32'h0};
    run_table("add", ops, as, bs);
  endtask

  task automatic test_sub();
    logic [2:0]  ops[] = '{3'b110, 3'b110, 3'b110};
    logic [31:0] as[]  = '{32'h7FFFFFFF, 32'h80000001, 32'hFFFFFFFF};
    logic [31:0] bs[]  = '{32'h80000001, 32'h7FFFFFF2, 32'hFFFFFFFF};
    run_table("sub", ops, as, bs);
  endtask

  task automatic test_slt();
    logic [2:0]  ops[] = '{3'b111, 3'b111, 3'b111, 3'b111};
    logic [31:0] as[]  = '{32'h7FFFFFFF, 32'h80000001, 32'h80000000, 32'h00000005};
    logic [31:0] bs[]  = '{32'hFFFFFFF2, 32'h00000001, 32'h7FFFFFFF, 32'h00000005};
    run_table("slt", ops, as, bs);
  endtask

  task automatic test_ext_ops();
    logic [2:0]  ops[] = '{3'b011, 3'b011, 3'b100, 3'b101, 3'b100, 3'b101};
    logic [31:0] as[]  = '{32'h00000001, 32'hFFFFFFFF, 32'hF0F0F0F0, 32'hF0F0F000, 32'hA5A5A5A5,
                           32'hFFFFFFFF};
    logic [31:0] bs[]  = '{32'hFFFFFFFF, 32'h00000001, 32'h0FF00FF0, 32'h00000F0F, 32'hA5A5A5A5,
                           32'h0};
    run_table("ext", ops, as, bs);
  endtask

  task automatic test_back_to_back();
    logic [31:0] corners[6] = '{32'h0, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000, 32'h1,
                                32'h80000001};
    logic [2:0]  ops[];
    logic [31:0] as[];
    logic [31:0] bs[];
    ops = new[300];
    as  = new[300];
    bs  = new[300];
    for (int i = 0; i < 300; i++) begin
      ops[i] = 3'($urandom_range(0, 7));
      as[i]  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
      bs[i]  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
    end
    run_table("b2b", ops, as, bs);
  endtask

  initial begin
    resetn = 1'b0;
    A      = '0;
    B      = '0;
    ALUop  = '0;
    repeat (2) @(posedge clk);
    #1;
    sb.delete();
    test_reset();
    test_logic();
    test_add();
    test_sub();
    test_slt();
    test_ext_ops();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
